fmap_rd_streamer: RTL and testbench
===================================

// Module: fmap_rd_streamer
// PURPOSE
//   Reads a finished output feature map from the feature BRAM (port B; port A is written
//   by the conv controller) and streams it out on a valid/ready interface with last-beat flag.
//   Start/len-driven burst; BRAM read latency hidden by credit-limited prefetch into an
//   internal FIFO; full rate (1 word/cycle) under no backpressure.
// PARAMETERS
//   DATA_WIDTH  16  width of feature word / stream data
//   ADDR_WIDTH  16  feature BRAM address width; also width of ibase_addr, ilen
//   RD_LAT      2   BRAM port-B read latency in cycles (enb@T -> doutb valid @T+RD_LAT), >=1
//   FIFO_DEPTH  4   output FIFO entries; must be >= RD_LAT+2 for full rate
// PORTS
//   iclk           in   1           clock, all logic rising-edge
//   irst           in   1           reset, synchronous, active-high
//   istart         in   1           1-cycle start pulse, honoured only in IDLE
//   ibase_addr     in   ADDR_WIDTH  first BRAM address, latched on accepted start
//   ilen           in   ADDR_WIDTH  word count, latched on accepted start (0 allowed)
//   obusy          out  1           high from cycle after accepted start until done cycle
//   odone          out  1           1-cycle pulse: burst complete
//   enb_f_read     out  1           feature BRAM port-B enable (one read per asserted cycle)
//   addrb_f_read   out  ADDR_WIDTH  feature BRAM port-B address
//   doutb_f_read   in   DATA_WIDTH  feature BRAM port-B read data, RD_LAT after enb
//   m_valid        out  1           stream data valid
//   m_ready        in   1           stream sink ready
//   m_data         out  DATA_WIDTH  stream data
//   m_last         out  1           high with final beat of burst
// BEHAVIOUR
//   Reset: obusy, odone, enb_f_read, m_valid, m_last = 0; addrb_f_read, m_data = 0;
//     FSM->IDLE, counters, read-pipe valid bits, FIFO all cleared. Reset mid-burst abandons
//     burst silently (no odone); in-flight BRAM data discarded.
//   FSM: IDLE --istart & ilen!=0--> RUN; IDLE --istart & ilen==0--> DONE;
//     RUN --all ilen reads issued--> DRAIN; DRAIN --final beat accepted--> DONE;
//     DONE (1 cycle, odone=1, obusy=0) --> IDLE. istart outside IDLE ignored.
//   Issue: enb_f_read=1 in RUN when issued<len and (inflight+fifo_count)<FIFO_DEPTH;
//     addrb_f_read = base+issued mod 2^ADDR_WIDTH (wraps, no error). First enb at T+1
//     for start sampled at T. enb_f_read=0 whenever not issuing; addrb holds last value.
//   Read pipe: RD_LAT-deep shift reg of valid bits tracks in-flight reads; at output,
//     doutb_f_read pushed into FIFO same cycle. Credit rule guarantees FIFO never overflows.
//   Stream: m_valid = !fifo_empty; m_data = FIFO head (registered); beat transfers on
//     m_valid&m_ready. m_valid held, m_data stable until transfer (no retraction).
//     m_last=1 iff head beat index == len-1. First m_valid at T+2+RD_LAT.
//   Simultaneous FIFO push+pop allowed (count unchanged), incl. at full/empty.
//   Order: beats emitted strictly in address order; exactly len beats per burst.
//   Throughput: m_ready held 1 -> one beat/cycle, len beats in len+RD_LAT+2 cycles to done.
//   odone at cycle after last transfer; next istart accepted the cycle after odone.
// STRUCTURE
//   conv_pkg: DATA_WIDTH/ADDR_WIDTH defaults, FSM state enum (IDLE,RUN,DRAIN,DONE).
//   Sub-module fmap_rd_fifo: sync FIFO (DEPTH, WIDTH=DATA_WIDTH+1 incl. last tag),
//     push/pop/full/empty/count, synchronous reset. Top holds FSM, counters, read pipe.
// TESTING
//   1 base=0x0010,len=8,m_ready=1 -> addrs 0x10..0x17 on consecutive cycles, 8 beats
//     back-to-back in order, m_last only on 8th, odone 1 cycle after it.
//   2 len=16, m_ready toggling 1/0 every cycle -> 16 beats in order, no loss/dup,
//     m_data stable while stalled, enb stops when inflight+count==FIFO_DEPTH.
//   3 len=0 -> no enb_f_read, no m_valid, odone pulse T+1, obusy stays 0.
//   4 base=0xFFFE,len=4 -> addrs 0xFFFE,0xFFFF,0x0000,0x0001; 4 beats.
//   5 istart pulsed again mid-burst (len=6) -> ignored, exactly 6 beats, one odone.
//   6 irst asserted after 3 beats of len=10, m_ready=0 -> next cycle all outputs 0,
//     no odone; new burst len=2 afterwards completes correctly.

Source files
------------

// File: rtl/fmap_rd_streamer_pkg.sv
// Shared types and defaults for the feature-map read streamer.
// Holds the FSM state encoding and a width helper used by the FIFO pointers.
package fmap_rd_streamer_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int RD_LAT_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Index width that stays at least one bit for single-entry storage.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/fmap_rd_streamer_if.sv
// Control, feature-BRAM port-B and output-stream signals of the read streamer.
// master = the streamer itself, slave = controller/BRAM/sink side.
interface fmap_rd_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  istart;
    logic [ADDR_WIDTH-1:0] ibase_addr;
    logic [ADDR_WIDTH-1:0] ilen;
    logic                  obusy;
    logic                  odone;
    logic                  enb_f_read;
    logic [ADDR_WIDTH-1:0] addrb_f_read;
    logic [DATA_WIDTH-1:0] doutb_f_read;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  istart, ibase_addr, ilen, doutb_f_read, m_ready,
        output obusy, odone, enb_f_read, addrb_f_read, m_valid, m_data, m_last
    );

    modport slave (
        output istart, ibase_addr, ilen, doutb_f_read, m_ready,
        input  obusy, odone, enb_f_read, addrb_f_read, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fmap_rd_streamer_fifo.sv
// Synchronous FIFO buffering BRAM read data (plus last tag) ahead of the stream.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module fmap_rd_streamer_fifo
    import fmap_rd_streamer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fmap_rd_streamer.sv
// Streams a finished feature map out of BRAM port B as a valid/ready burst.
// Reads are credit-limited so in-flight data always has a FIFO slot waiting.
module fmap_rd_streamer
    import fmap_rd_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               iclk,
    input  logic               irst,
    fmap_rd_streamer_if.master bus
);
    localparam int SW  = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q, len_q, issued_q, pushed_q, addr_q, addr_cur;
    logic [RD_LAT:1]       vld_q;
    logic [RD_LAT:0]       vld_pipe;
    logic [SW-1:0]         inflight;
    logic [FCW-1:0]        fifo_count;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic                  fifo_full, fifo_empty;
    logic                  start_ok, issue, push, pop, head_last, push_last;

    assign start_ok = (state == IDLE) && bus.istart;
    assign addr_cur = base_q + issued_q;

    // Reads still in the BRAM pipe; the output stage is pushing this cycle.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LAT; i++)
            inflight = inflight + SW'(vld_pipe[i]);
    end

    assign issue = (state == RUN) && (issued_q < len_q) && !fifo_full &&
                   ((inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH));

    assign vld_pipe  = {vld_q, issue};
    assign push      = vld_pipe[RD_LAT];
    assign push_last = (pushed_q == len_q - ADDR_WIDTH'(1));
    assign pop       = !fifo_empty && bus.m_ready;
    assign head_last = fifo_rdata[DATA_WIDTH];

    fmap_rd_streamer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk   (iclk),
        .rst   (irst),
        .push  (push),
        .wdata ({push_last, bus.doutb_f_read}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.istart) state_nxt = (bus.ilen != '0) ? RUN : DONE;
            RUN:     if (issue && (issued_q == len_q - ADDR_WIDTH'(1))) state_nxt = DRAIN;
            DRAIN:   if (pop && head_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            pushed_q <= '0;
            addr_q   <= '0;
            vld_q    <= '0;
        end else begin
            state <= state_nxt;
            vld_q <= vld_pipe[RD_LAT-1:0];
            if (start_ok) begin
                base_q   <= bus.ibase_addr;
                len_q    <= bus.ilen;
                issued_q <= '0;
                pushed_q <= '0;
            end
            if (issue) begin
                issued_q <= issued_q + ADDR_WIDTH'(1);
                addr_q   <= addr_cur;
            end
            if (push)
                pushed_q <= pushed_q + ADDR_WIDTH'(1);
        end
    end

    assign bus.obusy        = (state == RUN) || (state == DRAIN);
    assign bus.odone        = (state == DONE);
    assign bus.enb_f_read   = issue;
    assign bus.addrb_f_read = issue ? addr_cur : addr_q;
    assign bus.m_valid      = !fifo_empty;
    assign bus.m_data       = fifo_rdata[DATA_WIDTH-1:0];
    assign bus.m_last       = !fifo_empty && head_last;
endmodule

// File: tb/tb_fmap_rd_streamer.sv
// Scoreboard bench: expected reads/beats queued at start, monitor pops and compares.
// The BRAM is a random-content array behind an RD_LAT-cycle read pipe.
module tb_fmap_rd_streamer;
    localparam int DW = 16, AW = 16, RD_LAT = 2, FD = 4;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    fmap_rd_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fmap_rd_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus)
    );

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge iclk) begin
        rd_pipe[0] <= bus.enb_f_read ? mem[bus.addrb_f_read] : 16'hdead;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.doutb_f_read = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [AW-1:0] exp_addr [$];
    logic [DW:0]   exp_beat [$];
    int b_enb, b_beats, b_done, b_busy, done_cyc, last_enb_cyc;
    int mode = 3;
    bit stall_prev;
    logic [DW:0] stall_val, got, ex;
    logic [AW-1:0] ea;

    // m_ready pattern: 0 always, 1 toggle, 2 random, 3 never
    initial forever begin
        @(posedge iclk); #3;
        case (mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            2:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = 1'b0;
        endcase
    end

    always @(negedge iclk) begin
        if (irst) begin
            stall_prev = 1'b0;
        end else begin
            got = {bus.m_last, bus.m_data};
            if (stall_prev) begin
                check(bus.m_valid == 1'b1, "hold_valid", bus.m_valid, 1);
                check(got == stall_val, "hold_data", got, stall_val);
            end
            if (bus.enb_f_read) begin
                if (exp_addr.size() == 0) begin
                    check(1'b0, "extra_read", bus.addrb_f_read, 0);
                end else begin
                    ea = exp_addr.pop_front();
                    check(bus.addrb_f_read == ea, "rd_addr", bus.addrb_f_read, ea);
                end
                check(b_enb + 1 - b_beats <= FD, "credit", b_enb + 1 - b_beats, FD);
                if (mode == 0 && b_enb > 0)
                    check(cyc == last_enb_cyc + 1, "rd_gap", cyc, last_enb_cyc + 1);
                b_enb++;
                last_enb_cyc = cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_beat.size() == 0) begin
                    check(1'b0, "extra_beat", got, 0);
                end else begin
                    ex = exp_beat.pop_front();
                    check(got == ex, "beat", got, ex);
                end
                b_beats++;
            end
            if (bus.odone) begin
                b_done++;
                done_cyc = cyc;
            end
            if (bus.obusy) b_busy++;
            stall_prev = bus.m_valid && !bus.m_ready;
            stall_val  = got;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check(bus.obusy == 0,        {tag, "_obusy"},  bus.obusy, 0);
        check(bus.odone == 0,        {tag, "_odone"},  bus.odone, 0);
        check(bus.enb_f_read == 0,   {tag, "_enb"},    bus.enb_f_read, 0);
        check(bus.m_valid == 0,      {tag, "_valid"},  bus.m_valid, 0);
        check(bus.m_last == 0,       {tag, "_last"},   bus.m_last, 0);
        check(bus.addrb_f_read == 0, {tag, "_addrb"},  bus.addrb_f_read, 0);
        check(bus.m_data == 0,       {tag, "_data"},   bus.m_data, 0);
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input int len, output int t0);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_beat.push_back({i == len - 1, mem[a]});
        end
        b_enb = 0; b_beats = 0; b_done = 0; b_busy = 0; done_cyc = 0;
        @(posedge iclk); #2;
        bus.istart = 1'b1; bus.ibase_addr = base; bus.ilen = AW'(len);
        t0 = cyc;
        @(posedge iclk); #2;
        bus.istart = 1'b0;
    endtask

    task automatic finish_burst(input int len, input int md, input int t0);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(posedge iclk); #2;
            fin = (b_done > 0);
        end
        check(fin, "done_timeout", fin, 1);
        repeat (4) @(posedge iclk);
        #2;
        check(b_done == 1, "done_count", b_done, 1);
        check(b_beats == len, "beat_count", b_beats, len);
        check(b_enb == len, "read_count", b_enb, len);
        check(exp_beat.size() == 0, "beats_left", exp_beat.size(), 0);
        if (md == 0)
            check(done_cyc - t0 == ((len == 0) ? 1 : len + RD_LAT + 2), "latency",
                  done_cyc - t0, (len == 0) ? 1 : len + RD_LAT + 2);
        if (len == 0) check(b_busy == 0, "busy_len0", b_busy, 0);
    endtask

    task automatic run_burst(input logic [AW-1:0] base, input int len, input int md,
                             input bit restart);
        int t0;
        mode = md;
        start_burst(base, len, t0);
        if (restart) begin
            repeat (2) @(posedge iclk);
            #2;
            bus.istart = 1'b1; bus.ibase_addr = base + 16'h0100; bus.ilen = 16'd3;
            @(posedge iclk); #2;
            bus.istart = 1'b0;
        end
        finish_burst(len, md, t0);
    endtask

    initial begin
        int t0;
        bit seen;
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        bus.istart = 1'b0; bus.ibase_addr = '0; bus.ilen = '0;
        repeat (3) @(posedge iclk);
        #2;
        check_idle_outputs("reset");
        irst = 1'b0;

        run_burst(16'h0010, 8, 0, 1'b0);   // full rate
        run_burst(16'h0040, 16, 1, 1'b0);  // toggling backpressure
        run_burst(16'h1234, 0, 0, 1'b0);   // empty burst
        run_burst(16'hFFFE, 4, 0, 1'b0);   // address wrap
        run_burst(16'h0080, 6, 0, 1'b1);   // restart ignored mid-burst
        for (int k = 0; k < 5; k++)
            run_burst(AW'($urandom), int'($urandom_range(1, 24)), 2, 1'b0);

        // reset mid-burst abandons it silently
        mode = 0;
        start_burst(16'h0200, 10, t0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge iclk); #2;
            seen = (b_beats >= 3);
        end
        check(seen, "rst_wait_beats", b_beats, 3);
        mode = 3;
        @(posedge iclk); #2;
        irst = 1'b1;
        @(posedge iclk); #2;
        irst = 1'b0;
        check_idle_outputs("midrst");
        repeat (6) @(posedge iclk);
        #2;
        check(b_done == 0, "no_done_after_rst", b_done, 0);
        exp_addr.delete();
        exp_beat.delete();
        run_burst(16'h0300, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
